// File: rtl/sprite_blit_pkg.sv
// Shared types and default geometry for the sprite blitter slice.
// Widths here are the port widths the frame-buffer and ROM sides agree on.
package sprite_blit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE
  } blit_state_t;

  localparam int FB_W_DEF            = 320;
  localparam int FB_H_DEF            = 240;
  localparam int FB_ADDR_W           = 17;
  localparam int POS_W               = 10;
  localparam int ROM_ADDR_W          = 11;
  localparam int IDX_W_DEF           = 3;
  localparam int TRANSPARENT_IDX_DEF = 0;

endpackage

// File: rtl/sprite_blitter_if.sv
// Command, sprite-ROM and frame-buffer signals of the blitter, bundled.
// The slave modport is the blitter; the master modport is the game/ROM/FB side.
interface sprite_blitter_if
  import sprite_blit_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
);

  logic                  start;
  logic [POS_W-1:0]      pos_x;
  logic [POS_W-1:0]      pos_y;
  logic                  flip_x;
  logic                  busy;
  logic                  done;
  logic [ROM_ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]      rom_q;
  logic                  fb_we;
  logic [FB_ADDR_W-1:0]  fb_addr;
  logic [IDX_W-1:0]      fb_data;
  logic                  fb_ready;

  modport master (
    output start, pos_x, pos_y, flip_x, rom_q, fb_ready,
    input  busy, done, rom_address, fb_we, fb_addr, fb_data
  );

  modport slave (
    input  start, pos_x, pos_y, flip_x, rom_q, fb_ready,
    output busy, done, rom_address, fb_we, fb_addr, fb_data
  );

endinterface

// File: rtl/sprite_blit_addr.sv
// Row/column walk over the sprite plus the ROM and frame-buffer address arithmetic.
// Position sums are one bit wider than the position so values near 1023 never wrap on-screen.
module sprite_blit_addr
  import sprite_blit_pkg::*;
#(
  parameter int SPRITE_W = 30,
  parameter int SPRITE_H = 64,
  parameter int FB_W     = FB_W_DEF,
  parameter int FB_H     = FB_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [POS_W-1:0]      pos_x_i,
  input  logic [POS_W-1:0]      pos_y_i,
  input  logic                  flip_x_i,
  input  logic                  advance_i,
  output logic [ROM_ADDR_W-1:0] rom_address_o,
  output logic [FB_ADDR_W-1:0]  fb_addr_o,
  output logic                  on_screen_o,
  output logic                  last_pixel_o
);

  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int SUM_W = POS_W + 1;

  logic [POS_W-1:0] posX_q, posX_d;
  logic [POS_W-1:0] posY_q, posY_d;
  logic             flip_q, flip_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] srcCol;
  logic [SUM_W-1:0] xSum, ySum;
  logic             colLast, rowLast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      posX_q <= '0;
      posY_q <= '0;
      flip_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      posX_q <= posX_d;
      posY_q <= posY_d;
      flip_q <= flip_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  assign colLast = (col_q == COL_W'(SPRITE_W - 1));
  assign rowLast = (row_q == ROW_W'(SPRITE_H - 1));

  always_comb begin
    posX_d = posX_q;
    posY_d = posY_q;
    flip_d = flip_q;
    col_d  = col_q;
    row_d  = row_q;
    if (load_i) begin
      posX_d = pos_x_i;
      posY_d = pos_y_i;
      flip_d = flip_x_i;
      col_d  = '0;
      row_d  = '0;
    end else if (advance_i) begin
      if (colLast) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Only the ROM column is mirrored; the screen column always walks left to right.
  assign srcCol = flip_q ? (COL_W'(SPRITE_W - 1) - col_q) : col_q;

  assign xSum = {1'b0, posX_q} + SUM_W'(col_q);
  assign ySum = {1'b0, posY_q} + SUM_W'(row_q);

  assign on_screen_o  = (xSum < SUM_W'(FB_W)) && (ySum < SUM_W'(FB_H));
  assign last_pixel_o = colLast && rowLast;

  assign rom_address_o = ROM_ADDR_W'(row_q) * ROM_ADDR_W'(SPRITE_W) + ROM_ADDR_W'(srcCol);
  assign fb_addr_o     = FB_ADDR_W'(ySum) * FB_ADDR_W'(FB_W) + FB_ADDR_W'(xSum);

endmodule

// File: rtl/sprite_blitter.sv
// Copies one palette-indexed sprite from ROM into the frame buffer, skipping
// transparent and off-screen pixels; FETCH/WRITE pair per pixel, stalls on fb_ready.
module sprite_blitter
  import sprite_blit_pkg::*;
#(
  parameter int SPRITE_W        = 30,
  parameter int SPRITE_H        = 64,
  parameter int FB_W            = FB_W_DEF,
  parameter int FB_H            = FB_H_DEF,
  parameter int IDX_W           = IDX_W_DEF,
  parameter int TRANSPARENT_IDX = TRANSPARENT_IDX_DEF
) (
  input logic             vga_clk,
  input logic             reset,
  sprite_blitter_if.slave bus
);

  blit_state_t      state_q, state_d;
  logic             stall_q, stall_d;
  logic [IDX_W-1:0] fbData_q, fbData_d;
  logic [IDX_W-1:0] pixel;
  logic             load, advance, writeReq;
  logic             onScreen, lastPixel;

  sprite_blit_addr #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .FB_W     (FB_W),
    .FB_H     (FB_H)
  ) u_addr (
    .clk           (vga_clk),
    .rst           (reset),
    .load_i        (load),
    .pos_x_i       (bus.pos_x),
    .pos_y_i       (bus.pos_y),
    .flip_x_i      (bus.flip_x),
    .advance_i     (advance),
    .rom_address_o (bus.rom_address),
    .fb_addr_o     (bus.fb_addr),
    .on_screen_o   (onScreen),
    .last_pixel_o  (lastPixel)
  );

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      stall_q  <= 1'b0;
      fbData_q <= '0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      fbData_q <= fbData_d;
    end
  end

  // Once a write has stalled, the captured index is used instead of rom_q so the
  // write stays stable even if the ROM output moves underneath it.
  assign pixel    = stall_q ? fbData_q : bus.rom_q;
  assign writeReq = (state_q == WRITE) && onScreen && (pixel != IDX_W'(TRANSPARENT_IDX));

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    advance  = 1'b0;
    stall_d  = writeReq && !bus.fb_ready;
    fbData_d = (state_q == WRITE) ? pixel : fbData_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WRITE;
      WRITE: begin
        if (!writeReq || bus.fb_ready) begin
          advance = 1'b1;
          state_d = lastPixel ? DONE : FETCH;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q == FETCH) || (state_q == WRITE);
  assign bus.done    = (state_q == DONE);
  assign bus.fb_we   = writeReq;
  assign bus.fb_data = (state_q == WRITE) ? pixel : fbData_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench: a per-cycle timeline built from the blit rules is compared
// against the blitter on every cycle, plus literal checks on write counts and timing.
module tb_sprite_blitter;

  localparam int SW   = 30;
  localparam int SH   = 64;
  localparam int FBW  = 320;
  localparam int FBH  = 240;
  localparam int NPIX = SW * SH;
  localparam int MAXC = 6000;

  logic vga_clk = 1'b0;
  logic reset;
  logic garble;

  sprite_blitter_if #(.IDX_W(3)) bus ();

  sprite_blitter #(
    .SPRITE_W        (SW),
    .SPRITE_H        (SH),
    .FB_W            (FBW),
    .FB_H            (FBH),
    .IDX_W           (3),
    .TRANSPARENT_IDX (0)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  logic [2:0] rom [0:NPIX-1];

  // Synchronous sprite ROM; garble scrambles its output during stall cycles.
  always @(posedge vga_clk) bus.rom_q <= garble ? 3'($urandom) : rom[bus.rom_address];

  int expWe   [MAXC];
  int expAddr [MAXC];
  int expData [MAXC];
  int expRom  [MAXC];
  bit rdy     [MAXC];
  bit garb    [MAXC];
  int stallTab[NPIX];

  int doneOff, nWrites, firstAddr, lastAddr;
  int dutWrites, dutFirst, dutLast, dutDoneC, dutMaxAddr, dutZero, dut7, dutBad7;
  int curPx;
  int compared = 0;
  int mismatched = 0;

  task automatic checkVal(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // 0: all 5; 1: even columns transparent; 2: random opaque; 3: column 0 = 7, rest 1; 4: random with ~25% transparent
  task automatic fillRom(input int mode);
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        case (mode)
          0: rom[r*SW+c] = 3'd5;
          1: rom[r*SW+c] = (c % 2 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
          2: rom[r*SW+c] = 3'($urandom_range(1, 7));
          3: rom[r*SW+c] = (c == 0) ? 3'd7 : 3'd1;
          default: rom[r*SW+c] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        endcase
      end
    end
  endtask

  // 0: none; 1: first write waits 3; 2: random; 3: write 500 waits 10
  task automatic setStalls(input int mode);
    for (int k = 0; k < NPIX; k++) begin
      case (mode)
        1: stallTab[k] = (k == 0) ? 3 : 0;
        2: stallTab[k] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0;
        3: stallTab[k] = (k == 500) ? 10 : 0;
        default: stallTab[k] = 0;
      endcase
    end
  endtask

  // Walk the sprite in raster order: 2 cycles per pixel, plus the stall cycles of each accepted write.
  task automatic buildModel(input int px, input int py, input bit flip);
    int t, k, sc, v, x, y, st;
    t = 0;
    k = 0;
    for (int c = 0; c < MAXC; c++) begin
      expWe[c] = 0; expAddr[c] = 0; expData[c] = 0; expRom[c] = 0;
      rdy[c] = bit'($urandom_range(0, 1));
      garb[c] = 1'b0;
    end
    nWrites = 0; firstAddr = -1; lastAddr = -1;
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        sc = flip ? (SW - 1 - c) : c;
        v  = int'(rom[r*SW+sc]);
        x  = px + c;
        y  = py + r;
        expRom[t] = r*SW + sc;
        if (v != 0 && x < FBW && y < FBH) begin
          st = stallTab[k];
          for (int s = 0; s <= st; s++) begin
            expWe[t+1+s]   = 1;
            expAddr[t+1+s] = y*FBW + x;
            expData[t+1+s] = v;
            expRom[t+1+s]  = r*SW + sc;
            rdy[t+1+s]     = (s == st);
            garb[t+1+s]    = (s > 0);
          end
          if (firstAddr < 0) firstAddr = y*FBW + x;
          lastAddr = y*FBW + x;
          nWrites++;
          k++;
          t += 2 + st;
        end else begin
          expRom[t+1] = r*SW + sc;
          t += 2;
        end
      end
    end
    doneOff = t;
  endtask

  task automatic checkCycle(input int c);
    if (c <= doneOff) begin
      checkVal($sformatf("busy@%0d", c), int'(bus.busy), int'(c < doneOff));
      checkVal($sformatf("done@%0d", c), int'(bus.done), int'(c == doneOff));
      checkVal($sformatf("fb_we@%0d", c), int'(bus.fb_we), expWe[c]);
      if (c < doneOff) checkVal($sformatf("rom_address@%0d", c), int'(bus.rom_address), expRom[c]);
      if (expWe[c] != 0) begin
        checkVal($sformatf("fb_addr@%0d", c), int'(bus.fb_addr), expAddr[c]);
        checkVal($sformatf("fb_data@%0d", c), int'(bus.fb_data), expData[c]);
      end
    end else begin
      checkVal("idle busy", int'(bus.busy), 0);
      checkVal("idle done", int'(bus.done), 0);
      checkVal("idle fb_we", int'(bus.fb_we), 0);
    end
    if (bus.done && dutDoneC < 0) dutDoneC = c;
    if (bus.fb_we && bus.fb_ready) begin
      dutWrites++;
      if (dutFirst < 0) dutFirst = int'(bus.fb_addr);
      dutLast = int'(bus.fb_addr);
      if (int'(bus.fb_addr) > dutMaxAddr) dutMaxAddr = int'(bus.fb_addr);
      if (bus.fb_data == 3'd0) dutZero++;
      if (bus.fb_data == 3'd7) begin
        dut7++;
        if (int'(bus.fb_addr) % FBW != curPx + SW - 1) dutBad7++;
      end
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic applyStimulus(input int px, input int py, input bit flip, input int abortAt);
    buildModel(px, py, flip);
    curPx = px;
    dutWrites = 0; dutFirst = -1; dutLast = -1; dutDoneC = -1;
    dutMaxAddr = 0; dutZero = 0; dut7 = 0; dutBad7 = 0;
    bus.start  = 1'b1;
    bus.pos_x  = 10'(px);
    bus.pos_y  = 10'(py);
    bus.flip_x = flip;
    garble     = garb[0];
    @(posedge vga_clk);
    for (int c = 0; c <= doneOff + 1; c++) begin
      @(negedge vga_clk);
      bus.fb_ready = rdy[c];
      garble       = garb[c+1];
      bus.start    = (c <= doneOff) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.pos_x    = 10'($urandom);
      bus.pos_y    = 10'($urandom);
      bus.flip_x   = 1'($urandom);
      checkCycle(c);
      if (c == abortAt) begin
        #2 reset = 1'b1;
        #1;
        checkVal("fb_we after async reset", int'(bus.fb_we), 0);
        checkVal("busy after async reset", int'(bus.busy), 0);
        checkVal("done after async reset", int'(bus.done), 0);
        checkVal("fb_addr after async reset", int'(bus.fb_addr), 0);
        checkVal("rom_address after async reset", int'(bus.rom_address), 0);
        bus.start = 1'b0;
        garble    = 1'b0;
        @(negedge vga_clk);
        @(negedge vga_clk);
        reset = 1'b0;
        @(negedge vga_clk);
        checkVal("idle busy after reset release", int'(bus.busy), 0);
        return;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int wantWrites, input int wantDone);
    checkVal({tag, " model writes"}, nWrites, wantWrites);
    checkVal({tag, " dut writes"}, dutWrites, wantWrites);
    checkVal({tag, " model done offset"}, doneOff, wantDone);
    checkVal({tag, " dut done offset"}, dutDoneC, wantDone);
  endtask

  initial begin
    reset        = 1'b1;
    garble       = 1'b0;
    bus.start    = 1'b0;
    bus.pos_x    = '0;
    bus.pos_y    = '0;
    bus.flip_x   = 1'b0;
    bus.fb_ready = 1'b1;
    fillRom(0);
    repeat (3) @(negedge vga_clk);
    checkVal("reset busy", int'(bus.busy), 0);
    checkVal("reset done", int'(bus.done), 0);
    checkVal("reset fb_we", int'(bus.fb_we), 0);
    checkVal("reset rom_address", int'(bus.rom_address), 0);
    checkVal("reset fb_addr", int'(bus.fb_addr), 0);
    checkVal("reset fb_data", int'(bus.fb_data), 0);
    reset = 1'b0;
    @(negedge vga_clk);

    $display("[TB] opaque sprite at origin");
    fillRom(0); setStalls(0);
    applyStimulus(0, 0, 1'b0, -1);
    checkOutput("opaque", 1920, 3840);
    checkVal("opaque model first addr", firstAddr, 0);
    checkVal("opaque model last addr", lastAddr, 20189);
    checkVal("opaque dut first addr", dutFirst, 0);
    checkVal("opaque dut last addr", dutLast, 20189);

    $display("[TB] transparent even columns");
    fillRom(1); setStalls(0);
    applyStimulus(40, 20, 1'b0, -1);
    checkOutput("keyed", 960, 3840);
    checkVal("keyed zero-index writes", dutZero, 0);

    $display("[TB] clipped at (300,200)");
    fillRom(2); setStalls(0);
    applyStimulus(300, 200, 1'($urandom), -1);
    checkOutput("clipped", 800, 3840);
    checkVal("clipped addr in range", int'(dutMaxAddr < FBW*FBH), 1);

    $display("[TB] horizontal flip");
    fillRom(3); setStalls(0);
    applyStimulus(100, 50, 1'b1, -1);
    checkOutput("flip", 1920, 3840);
    checkVal("flip index-7 writes", dut7, 64);
    checkVal("flip index-7 off column", dutBad7, 0);

    $display("[TB] three-cycle stall on first write");
    fillRom(0); setStalls(1);
    applyStimulus(0, 0, 1'b0, -1);
    checkOutput("stall3", 1920, 3843);

    $display("[TB] reset mid-stall at pixel 500");
    fillRom(0); setStalls(3);
    applyStimulus(0, 0, 1'b0, 1005);
    checkVal("model write at abort cycle", expWe[1005], 1);
    fillRom(0); setStalls(0);
    applyStimulus(5, 7, 1'b1, -1);
    checkOutput("after reset", 1920, 3840);

    $display("[TB] position beyond 1023 wrap point");
    fillRom(2); setStalls(2);
    applyStimulus(1010, 1000, 1'b0, -1);
    checkVal("wrap dut writes", dutWrites, 0);
    checkVal("wrap dut done offset", dutDoneC, 3840);

    $display("[TB] randomized blits");
    for (int i = 0; i < 4; i++) begin
      fillRom(4); setStalls(2);
      applyStimulus(int'($urandom_range(0, 340)), int'($urandom_range(0, 250)), 1'($urandom), -1);
      checkVal($sformatf("random %0d dut writes", i), dutWrites, nWrites);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
